riscv_execute_md: RTL
=====================

# riscv_execute_md

Parametrised RV32IM execute stage: E pipeline register, operand forwarding, ALU, full funct3 branch resolution, and an iterative multiply/divide unit (MDU). It sits between decode and memory. While an M-extension op is in E, it stalls the front end. XLEN and MDU presence are configurable.

## Interface
Parameters:
- XLEN, 32, datapath width
- MD_EN, 1, 1 = MDU present; 0 = MDU removed, o_md_busyE tied 0, md ops execute as bubbles

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_flushE  in  1  load bubble into E register
- i_ctrl_reg_wr_enD  in  1  writeback enable
- i_ctrl_result_srcD  in  2  writeback select, passed through
- i_ctrl_mem_wr_enD  in  1  store enable
- i_ctrl_pc_modeD  in  2  00 none, 01 branch, 10 jal, 11 jalr
- i_ctrl_alu_ctrlD  in  4  ALU op code
- i_ctrl_alu_srcD  in  1  0 = forwarded rs2, 1 = immediate
- i_ctrl_md_enD  in  1  M-extension op; funct3 selects it
- i_ctrl_funct3D  in  3  branch / MDU sub-op
- i_rs1_dataD, i_rs2_dataD  in  XLEN  register file data
- i_rs1_addrD, i_rs2_addrD, i_rd_addrD  in  5  register addresses
- i_PCD, i_ExtImmD, i_PCPlus4D  in  XLEN  PC, immediate, PC+4
- i_forwardAE, i_forwardBE  in  2  00 reg, 01 W, 10 M
- i_alu_resultM, i_rd_dataW  in  XLEN  forwarding sources
- o_ctrl_reg_wr_enE, o_ctrl_mem_wr_enE  out  1  registered control
- o_ctrl_result_srcE  out  2  registered control
- o_rs1_addrE, o_rs2_addrE, o_rd_addrE  out  5  to hazard unit and M stage
- o_resultE  out  XLEN  ALU result, or MDU result when md_enE
- o_mem_writedataE  out  XLEN  forwarded rs2
- o_PCTargetE, o_PCPlus4E  out  XLEN  jump/branch target, link value
- o_PCSrcE  out  2  00 PC+4, 01 target, 10 jalr target
- o_md_busyE  out  1  stall request to hazard unit (F, D, E hold; M receives bubble)

## Operation
- E register: loads D inputs every cycle when o_md_busyE=0.
  - i_flushE=1 loads a bubble: reg_wr_en, mem_wr_en, pc_mode and md_en are 0; other fields are don't-care.
  - While busy, the register holds and i_flushE is ignored.
- Forwarding: SrcA = mux(i_forwardAE); the writedata mux uses i_forwardBE. SrcB = alu_src ? ExtImmE : writedata.
- Branch decision is computed directly from SrcA/SrcB:
  - BEQ / BNE: equality
  - BLT / BGE: signed compare
  - BLTU / BGEU: unsigned compare
  - funct3 010/011: not taken
- o_PCSrcE:
  - 10 if pc_mode=jalr
  - 01 if pc_mode=jal, or pc_mode=branch and taken
  - otherwise 00
  - Bubbles give 00.
- o_PCTargetE = jalr ? (SrcA+ExtImmE) with bit0 cleared : PCE+ExtImmE.
- MDU FSM: IDLE → RUN → DONE → IDLE.
  - IDLE with md_enE: latch SrcA, writedata and funct3; → RUN, counter=0.
  - RUN: one radix-2 step per cycle (shift-add multiply / restoring divide on magnitudes); → DONE when counter=XLEN-1.
  - DONE: sign-correct and present result; → IDLE.
- o_md_busyE = md_enE && state≠DONE (combinational).
- Sub-ops by funct3:
  - 000 MUL: low product
  - 001 MULH: high, signed×signed
  - 010 MULHSU: high, signed×unsigned
  - 011 MULHU: high, unsigned×unsigned
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Divide by zero: quotient all-ones, remainder = dividend.
- Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder 0.
- Latency is fixed in all cases; there is no early exit.

## Timing
- Non-MDU ops: one cycle in E; all E outputs are combinational from the E register and the forwarding inputs.
- MDU ops: XLEN+2 cycles in E (IDLE cycle, XLEN RUN cycles, DONE cycle); o_md_busyE is high for XLEN+1 cycles.
  - o_resultE is valid in the DONE cycle and is consumed by M at that edge.
  - Operands are latched in the first cycle, so later changes on the forwarding sources do not affect the result.
- Back-to-back MDU ops: the second enters E at the DONE edge and starts in IDLE at the next cycle.
- Reset (async, any cycle including mid-RUN): all E register fields 0, FSM IDLE, counter 0, o_md_busyE=0, o_PCSrcE=00, o_resultE=0. The partial result is discarded.

## Structure
- The shared riscv_configs package holds:
  - XLEN default
  - ALU op codes
  - FUNCT3 branch and MDU codes
  - PC-mode codes
  - MDU state encoding
- The iterative unit is the sub-module riscv_mdu (start, funct3, a, b → busy, done, result), instantiated under MD_EN.
- The E register, forwarding muxes, branch compare and ALU stay in the top block.

## Test plan
- BLT, SrcA=0xFFFFFFFF, SrcB=1, PCE=0x100, imm=0x20 → o_PCSrcE=01, o_PCTargetE=0x120; the same operands with BLTU → 00.
- JALR, rs1=0x1003, imm=4 → o_PCSrcE=10, o_PCTargetE=0x1006, o_PCPlus4E=PCE+4.
- 0xFFFFFFFF × 2:
  - MUL → 0xFFFFFFFE; o_md_busyE high exactly 33 cycles, result in the 34th.
  - MULH → 0xFFFFFFFF.
  - MULHU → 0x00000001.
  - MULHSU → 0xFFFFFFFF.
- Division corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7.
  - DIV −7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
- Forwarding and flush:
  - forwardAE=10 with M=5 and reg=9, ADD imm 1 → o_resultE=6.
  - MDU operand forwarded from M, then M changes during the stall → result unchanged.
  - i_flushE during busy → ignored.
- Reset asserted in RUN cycle 10 of a DIV → o_md_busyE and all outputs 0 immediately; after release, a MUL 3×4 → 12 with nominal latency.

Source files
------------

// File: rtl/riscv_configs_pkg.sv
// Shared RV32IM configuration: datapath width, ALU op codes, funct3 codes,
// PC-mode codes and the multiply/divide unit state encoding.
package riscv_configs;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_NONE   = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JAL    = 2'b10,
        PC_JALR   = 2'b11
    } pc_mode_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;
    localparam logic [2:0] F3_BLT    = 3'b100;
    localparam logic [2:0] F3_BGE    = 3'b101;
    localparam logic [2:0] F3_BLTU   = 3'b110;
    localparam logic [2:0] F3_BGEU   = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/riscv_mdu.sv
// Iterative radix-2 multiply/divide unit: magnitudes are processed for XLEN
// cycles, then the sign is applied on the way out in the DONE state.
module riscv_mdu
    import riscv_configs::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    localparam int CW = $clog2(XLEN);

    md_state_e       r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_acc, r_lo, r_m, r_a_orig;
    logic [2:0]      r_funct3;
    logic            r_b_zero, r_neg_q, r_neg_r;

    logic            w_a_signed, w_b_signed, w_sa, w_sb;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic [XLEN:0]   w_add, w_shift, w_diff;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0] w_quo, w_rem;

    // Operand sign handling and one multiply / divide step of datapath
    always_comb begin
        w_a_signed = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) ||
                     (i_funct3 == F3_DIV)  || (i_funct3 == F3_REM);
        w_b_signed = (i_funct3 == F3_MULH) || (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
        w_sa       = w_a_signed & i_a[XLEN-1];
        w_sb       = w_b_signed & i_b[XLEN-1];
        w_mag_a    = w_sa ? (-i_a) : i_a;
        w_mag_b    = w_sb ? (-i_b) : i_b;
        w_add      = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
        w_shift    = {r_acc, r_lo[XLEN-1]};
        w_diff     = w_shift - {1'b0, r_m};
    end

    // Sequencer: latch operands, step XLEN times, hold result for one cycle
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= MD_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_a_orig <= '0;
            r_funct3 <= 3'b000;
            r_b_zero <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_state  <= MD_RUN;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_lo     <= i_funct3[2] ? w_mag_a : w_mag_b;
                        r_m      <= i_funct3[2] ? w_mag_b : w_mag_a;
                        r_a_orig <= i_a;
                        r_funct3 <= i_funct3;
                        r_b_zero <= (i_b == {XLEN{1'b0}});
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                    end
                end
                MD_RUN: begin
                    if (r_funct3[2]) begin
                        // restoring divide: quotient bits shift into r_lo
                        if (!w_diff[XLEN]) begin
                            r_acc <= w_diff[XLEN-1:0];
                            r_lo  <= {r_lo[XLEN-2:0], 1'b1};
                        end else begin
                            r_acc <= w_shift[XLEN-1:0];
                            r_lo  <= {r_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        r_acc <= w_add[XLEN:1];
                        r_lo  <= {w_add[0], r_lo[XLEN-1:1]};
                    end
                    if (r_cnt == CW'(XLEN-1)) begin
                        r_state <= MD_DONE;
                    end
                    r_cnt <= r_cnt + CW'(1);
                end
                MD_DONE: begin
                    r_state <= MD_IDLE;
                    r_cnt   <= '0;
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    // Sign correction and sub-op result selection
    always_comb begin
        w_prod   = {r_acc, r_lo};
        w_prod_s = r_neg_q ? (-w_prod) : w_prod;
        w_quo    = r_b_zero ? {XLEN{1'b1}} : (r_neg_q ? (-r_lo) : r_lo);
        w_rem    = r_b_zero ? r_a_orig : (r_neg_r ? (-r_acc) : r_acc);
        case (r_funct3)
            F3_MUL:                         o_result = w_prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:   o_result = w_prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:                o_result = w_quo;
            F3_REM, F3_REMU:                o_result = w_rem;
            default:                        o_result = {XLEN{1'b0}};
        endcase
        o_done = (r_state == MD_DONE);
        o_busy = (r_state == MD_RUN) || ((r_state == MD_IDLE) && i_start);
    end

endmodule

// File: rtl/riscv_execute_md.sv
// RV32IM execute stage: E pipeline register, forwarding, ALU, branch
// resolution and the optional iterative multiply/divide unit.
module riscv_execute_md
    import riscv_configs::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter bit MD_EN = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_flushE,
    input  logic            i_ctrl_reg_wr_enD,
    input  logic [1:0]      i_ctrl_result_srcD,
    input  logic            i_ctrl_mem_wr_enD,
    input  logic [1:0]      i_ctrl_pc_modeD,
    input  logic [3:0]      i_ctrl_alu_ctrlD,
    input  logic            i_ctrl_alu_srcD,
    input  logic            i_ctrl_md_enD,
    input  logic [2:0]      i_ctrl_funct3D,
    input  logic [XLEN-1:0] i_rs1_dataD,
    input  logic [XLEN-1:0] i_rs2_dataD,
    input  logic [4:0]      i_rs1_addrD,
    input  logic [4:0]      i_rs2_addrD,
    input  logic [4:0]      i_rd_addrD,
    input  logic [XLEN-1:0] i_PCD,
    input  logic [XLEN-1:0] i_ExtImmD,
    input  logic [XLEN-1:0] i_PCPlus4D,
    input  logic [1:0]      i_forwardAE,
    input  logic [1:0]      i_forwardBE,
    input  logic [XLEN-1:0] i_alu_resultM,
    input  logic [XLEN-1:0] i_rd_dataW,
    output logic            o_ctrl_reg_wr_enE,
    output logic            o_ctrl_mem_wr_enE,
    output logic [1:0]      o_ctrl_result_srcE,
    output logic [4:0]      o_rs1_addrE,
    output logic [4:0]      o_rs2_addrE,
    output logic [4:0]      o_rd_addrE,
    output logic [XLEN-1:0] o_resultE,
    output logic [XLEN-1:0] o_mem_writedataE,
    output logic [XLEN-1:0] o_PCTargetE,
    output logic [XLEN-1:0] o_PCPlus4E,
    output logic [1:0]      o_PCSrcE,
    output logic            o_md_busyE
);
    localparam int SW = $clog2(XLEN);

    logic            r_reg_wr_en, r_mem_wr_en, r_alu_src, r_md_en;
    logic [1:0]      r_result_src, r_pc_mode;
    logic [3:0]      r_alu_ctrl;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_rs1_data, r_rs2_data, r_pc, r_imm, r_pc_plus4;
    logic [4:0]      r_rs1_addr, r_rs2_addr, r_rd_addr;

    logic            w_bubble, w_md_busy, w_md_done, w_eq, w_lt, w_ltu, w_taken;
    logic [XLEN-1:0] w_srcA, w_wdata, w_srcB, w_alu, w_md_result, w_jalr_sum;
    logic [SW-1:0]   w_shamt;

    // Without an MDU, M-extension ops are turned into bubbles on entry
    assign w_bubble = i_flushE || (!MD_EN && i_ctrl_md_enD);

    // E pipeline register; holds while the MDU stalls the front end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_reg_wr_en  <= 1'b0;
            r_mem_wr_en  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_md_en      <= 1'b0;
            r_result_src <= 2'b00;
            r_pc_mode    <= 2'b00;
            r_alu_ctrl   <= 4'b0000;
            r_funct3     <= 3'b000;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_pc         <= '0;
            r_imm        <= '0;
            r_pc_plus4   <= '0;
            r_rs1_addr   <= 5'd0;
            r_rs2_addr   <= 5'd0;
            r_rd_addr    <= 5'd0;
        end else if (!o_md_busyE) begin
            r_reg_wr_en  <= i_ctrl_reg_wr_enD & ~w_bubble;
            r_mem_wr_en  <= i_ctrl_mem_wr_enD & ~w_bubble;
            r_pc_mode    <= w_bubble ? 2'b00 : i_ctrl_pc_modeD;
            r_md_en      <= i_ctrl_md_enD & ~w_bubble;
            r_alu_src    <= i_ctrl_alu_srcD;
            r_result_src <= i_ctrl_result_srcD;
            r_alu_ctrl   <= i_ctrl_alu_ctrlD;
            r_funct3     <= i_ctrl_funct3D;
            r_rs1_data   <= i_rs1_dataD;
            r_rs2_data   <= i_rs2_dataD;
            r_pc         <= i_PCD;
            r_imm        <= i_ExtImmD;
            r_pc_plus4   <= i_PCPlus4D;
            r_rs1_addr   <= i_rs1_addrD;
            r_rs2_addr   <= i_rs2_addrD;
            r_rd_addr    <= i_rd_addrD;
        end
    end

    // Forwarding muxes and ALU
    always_comb begin
        case (i_forwardAE)
            2'b01:   w_srcA = i_rd_dataW;
            2'b10:   w_srcA = i_alu_resultM;
            default: w_srcA = r_rs1_data;
        endcase
        case (i_forwardBE)
            2'b01:   w_wdata = i_rd_dataW;
            2'b10:   w_wdata = i_alu_resultM;
            default: w_wdata = r_rs2_data;
        endcase
        w_srcB  = r_alu_src ? r_imm : w_wdata;
        w_shamt = w_srcB[SW-1:0];
        w_eq    = (w_srcA == w_srcB);
        w_lt    = ($signed(w_srcA) < $signed(w_srcB));
        w_ltu   = (w_srcA < w_srcB);
        case (r_alu_ctrl)
            ALU_ADD:   w_alu = w_srcA + w_srcB;
            ALU_SUB:   w_alu = w_srcA - w_srcB;
            ALU_AND:   w_alu = w_srcA & w_srcB;
            ALU_OR:    w_alu = w_srcA | w_srcB;
            ALU_XOR:   w_alu = w_srcA ^ w_srcB;
            ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, w_lt};
            ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, w_ltu};
            ALU_SLL:   w_alu = w_srcA << w_shamt;
            ALU_SRL:   w_alu = w_srcA >> w_shamt;
            ALU_SRA:   w_alu = $signed(w_srcA) >>> w_shamt;
            ALU_PASSB: w_alu = w_srcB;
            default:   w_alu = {XLEN{1'b0}};
        endcase
    end

    // Branch resolution and next-PC selection
    always_comb begin
        case (r_funct3)
            F3_BEQ:  w_taken = w_eq;
            F3_BNE:  w_taken = ~w_eq;
            F3_BLT:  w_taken = w_lt;
            F3_BGE:  w_taken = ~w_lt;
            F3_BLTU: w_taken = w_ltu;
            F3_BGEU: w_taken = ~w_ltu;
            default: w_taken = 1'b0;
        endcase
        case (r_pc_mode)
            PC_JALR:   o_PCSrcE = 2'b10;
            PC_JAL:    o_PCSrcE = 2'b01;
            PC_BRANCH: o_PCSrcE = w_taken ? 2'b01 : 2'b00;
            default:   o_PCSrcE = 2'b00;
        endcase
        w_jalr_sum = w_srcA + r_imm;
        if (r_pc_mode == PC_JALR) begin
            o_PCTargetE = {w_jalr_sum[XLEN-1:1], 1'b0};
        end else begin
            o_PCTargetE = r_pc + r_imm;
        end
    end

    generate
        if (MD_EN) begin : g_mdu
            riscv_mdu #(.XLEN(XLEN)) u_mdu (
                .i_clk    (i_clk),
                .i_rstn   (i_rstn),
                .i_start  (r_md_en),
                .i_funct3 (r_funct3),
                .i_a      (w_srcA),
                .i_b      (w_wdata),
                .o_busy   (w_md_busy),
                .o_done   (w_md_done),
                .o_result (w_md_result)
            );
        end else begin : g_no_mdu
            assign w_md_busy   = 1'b0;
            assign w_md_done   = 1'b0;
            assign w_md_result = {XLEN{1'b0}};
        end
    endgenerate

    assign o_md_busyE         = r_md_en & w_md_busy;
    assign o_resultE          = r_md_en ? (w_md_done ? w_md_result : {XLEN{1'b0}}) : w_alu;
    assign o_mem_writedataE   = w_wdata;
    assign o_PCPlus4E         = r_pc_plus4;
    assign o_ctrl_reg_wr_enE  = r_reg_wr_en;
    assign o_ctrl_mem_wr_enE  = r_mem_wr_en;
    assign o_ctrl_result_srcE = r_result_src;
    assign o_rs1_addrE        = r_rs1_addr;
    assign o_rs2_addrE        = r_rs2_addr;
    assign o_rd_addrE         = r_rd_addr;

endmodule
